i2s_adc_receiver: RTL and testbench
===================================

# i2s_adc_receiver

Deserialises the audio codec's ADC stream (I2S, MSB first, one-bit delay after LR clock edge) into parallel left/right sample pairs in the system clock domain. It is the record-path counterpart of the DAC transmit path inside the audio front end. Its pins are AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT; the clock generator elsewhere drives the bit and LR clocks. Captured pairs are offered to downstream logic through a valid/ready handshake, for example to a future record-to-note-memory datapath.

## Interface
- DATA_WIDTH, 16: bits per channel captured; codec word bits beyond this are ignored.
- SYNC_STAGES, 2: flip-flop synchroniser depth on each pin input (≥2).
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- aud_bclk  in  1  codec bit clock, asynchronous to clk.
- aud_adclrck  in  1  ADC LR clock; 0 = left, 1 = right.
- aud_adcdat  in  1  ADC serial data, valid at BCLK rising edge.
- sample_left  out  DATA_WIDTH  left sample of current pair, two's complement.
- sample_right  out  DATA_WIDTH  right sample of current pair.
- sample_valid  out  1  pair available.
- sample_ready  in  1  consumer accepts the pair when valid && ready.
- overrun  out  1  sticky: a completed pair was dropped because the output was still full.
- frame_err  out  1  sticky: the LR clock toggled before DATA_WIDTH bits were captured.
- clr_flags  in  1  single-cycle pulse clears overrun and frame_err.

## Operation
- All three pins pass through SYNC_STAGES flops with equal delay. A rising BCLK is detected as sync=1 when the previous sync value was 0. All capture logic acts only on detected rising edges.
- The LR level is sampled at each BCLK rising edge. An LR change relative to the previous sample is an LR edge.
- FSM states:
  - SEEK: after reset; wait for an LR 1→0 edge, which is the start of a left word, then go to DELAY.
  - DELAY: on the next BCLK rise, discard the bit (I2S delay), clear the bit counter, go to SHIFT.
  - SHIFT: shift the data bit in MSB first at each BCLK rise and increment the counter. When the counter reaches DATA_WIDTH, store the word into the channel holding register and go to PAD.
  - PAD: ignore bits until the next LR edge, then go to DELAY.
- An LR edge occurring while in SHIFT is a short word:
  - set frame_err;
  - discard the partial word and any held left word;
  - go to DELAY if the edge is 1→0, otherwise to SEEK.
- Pair completion happens when a right word is stored while a left word is held. It produces a load request on the next clk cycle.
- Output register behaviour on a load request:
  - If !sample_valid, or sample_valid && sample_ready in the same cycle: load both samples and set sample_valid.
  - Otherwise: keep the old pair, drop the new one, set overrun.
- sample_valid clears on valid && ready when no load request is present. Samples are stable while valid is high.
- clr_flags together with a new flag event in the same cycle: the event wins and the flag stays 1.
- Reset values: sample_left=0, sample_right=0, sample_valid=0, overrun=0, frame_err=0, FSM=SEEK.

## Timing
- Input requirement: BCLK high and low phases each ≥ SYNC_STAGES+1 clk periods. At 3.072 MHz BCLK with a 50 MHz clk this gives ≥8 periods; faster BCLK is unsupported.
- Latency: sample_valid rises exactly SYNC_STAGES+2 clk cycles after the pin-level BCLK rising edge that carries the right word's last captured bit.
- Throughput: one pair per LR period. The consumer must assert ready within one LR period to avoid overrun.
- Reset asserted mid-word: all state is lost immediately. After release, capture resumes at the next LR 1→0 edge, so no partial pair is ever emitted.

## Structure
- Shared package audio_pkg: DATA_WIDTH default, FSM state enum (SEEK/DELAY/SHIFT/PAD), LR_LEFT=0 / LR_RIGHT=1 constants.
- Sub-module sync_edge: parameterised synchroniser plus rising-edge pulse. Instantiate it for BCLK; use the same flop chain, without edge output, for LRCK and DATA.

## Test plan
- Reset, then 3 I2S frames (32-bit slots) with L=16'hA5C3, R=16'h3C5A -> first pair appears after the second LR 1→0 alignment; sample_left=A5C3, sample_right=3C5A; valid latency = SYNC_STAGES+2 cycles from the right LSB edge.
- ready held 0 across two frames -> the first pair is retained; overrun=1 after the second pair completes; clr_flags pulse -> overrun=0.
- ready asserted in the same cycle a new pair loads -> the old pair is accepted, the new pair is loaded, and valid stays 1 with no overrun.
- LR toggles after 10 bits of a right word -> frame_err=1, no pair is emitted, and the next full frame is captured correctly.
- reset pulled low mid-SHIFT of a left word, then released -> all outputs are 0, and the first pair after release contains only full post-reset words.
- Full-scale values 16'h8000 / 16'h7FFF, with 24-bit codec words carrying trailing bits -> the top 16 bits are captured exactly and the trailing bits are ignored.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio front-end serial paths.
package audio_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } i2s_state_t;

endpackage

// File: rtl/sync_edge.sv
// Pin synchroniser: one edge-detected input plus WIDTH plain inputs, all sharing
// the same STAGES-deep flop chain so they stay aligned to each other.
module sync_edge #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             edge_in,
    input  logic [WIDTH-1:0] level_in,
    output logic [WIDTH-1:0] level_out,
    output logic             rise
);

    logic [WIDTH:0] chain [STAGES];
    logic           edge_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
            edge_prev <= 1'b0;
        end else begin
            chain[0] <= {level_in, edge_in};
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            edge_prev <= chain[STAGES-1][0];
        end
    end

    assign level_out = chain[STAGES-1][WIDTH:1];
    assign rise      = chain[STAGES-1][0] & ~edge_prev;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC record-path receiver: deserialises left/right words from the codec and
// hands complete pairs to the system clock domain through valid/ready.
//
// state | meaning
// SEEK  | unaligned; waiting for an LR 1->0 edge (start of a left word)
// DELAY | discard the single I2S delay bit, clear the bit counter
// SHIFT | shifting data bits in MSB first
// PAD   | word stored; ignoring trailing bits until the next LR edge
module i2s_adc_receiver
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    output logic [DATA_WIDTH-1:0] sample_left,
    output logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overrun,
    output logic                  frame_err,
    input  logic                  clr_flags
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [1:0]            pins_sync;
    logic                  bclk_rise;
    logic                  lr_s;
    logic                  dat_s;

    i2s_state_t            state;
    i2s_state_t            state_nxt;
    logic                  lr_prev;
    logic                  lr_edge;
    logic                  lr_fall;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] hold_left;
    logic [DATA_WIDTH-1:0] hold_right;
    logic                  chan;
    logic                  left_held;
    logic                  load_req;

    logic                  do_shift;
    logic                  word_done;
    logic                  short_word;
    logic                  enter_delay;
    logic                  clr_cnt;

    sync_edge #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .edge_in   (aud_bclk),
        .level_in  ({aud_adcdat, aud_adclrck}),
        .level_out (pins_sync),
        .rise      (bclk_rise)
    );

    assign lr_s      = pins_sync[0];
    assign dat_s     = pins_sync[1];
    assign lr_edge   = bclk_rise && (lr_s != lr_prev);
    assign lr_fall   = lr_edge && (lr_s == LR_LEFT);
    assign shift_nxt = {shift_reg[DATA_WIDTH-2:0], dat_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        do_shift    = 1'b0;
        word_done   = 1'b0;
        short_word  = 1'b0;
        enter_delay = 1'b0;
        clr_cnt     = 1'b0;
        case (state)
            SEEK: begin
                if (lr_fall) begin
                    state_nxt   = DELAY;
                    enter_delay = 1'b1;
                end
            end
            DELAY: begin
                if (bclk_rise) begin
                    state_nxt = SHIFT;
                    clr_cnt   = 1'b1;
                end
            end
            SHIFT: begin
                // An LR edge here means the codec word was shorter than DATA_WIDTH.
                if (lr_edge) begin
                    short_word = 1'b1;
                    if (lr_fall) begin
                        state_nxt   = DELAY;
                        enter_delay = 1'b1;
                    end else begin
                        state_nxt = SEEK;
                    end
                end else if (bclk_rise) begin
                    do_shift = 1'b1;
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        word_done = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (lr_edge) begin
                    state_nxt   = DELAY;
                    enter_delay = 1'b1;
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lr_prev    <= 1'b0;
            chan       <= LR_LEFT;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            left_held  <= 1'b0;
            load_req   <= 1'b0;
        end else begin
            load_req <= 1'b0;
            if (bclk_rise) begin
                lr_prev <= lr_s;
            end
            if (enter_delay) begin
                chan <= lr_s;
            end
            if (clr_cnt) begin
                bit_cnt <= '0;
            end else if (do_shift) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (do_shift) begin
                shift_reg <= shift_nxt;
            end
            if (short_word) begin
                left_held <= 1'b0;
            end
            if (word_done) begin
                if (chan == LR_LEFT) begin
                    hold_left <= shift_nxt;
                    left_held <= 1'b1;
                end else begin
                    hold_right <= shift_nxt;
                    left_held  <= 1'b0;
                    load_req   <= left_held;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (load_req) begin
                if (!sample_valid || sample_ready) begin
                    sample_left  <= hold_left;
                    sample_right <= hold_right;
                    sample_valid <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            overrun   <= (load_req && sample_valid && !sample_ready) || (overrun && !clr_flags);
            frame_err <= short_word || (frame_err && !clr_flags);
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: slot-level stream model plus cycle compare.
module tb_i2s_adc_receiver;

    localparam int DW          = 16;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          aud_bclk;
    logic          aud_adclrck;
    logic          aud_adcdat;
    logic [DW-1:0] sample_left;
    logic [DW-1:0] sample_right;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;
    logic          frame_err;
    logic          clr_flags;

    always #10 clk = ~clk;

    i2s_adc_receiver #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .aud_bclk     (aud_bclk),
        .aud_adclrck  (aud_adclrck),
        .aud_adcdat   (aud_adcdat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .frame_err    (frame_err),
        .clr_flags    (clr_flags)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_ev_t;

    int       vectors = 0;
    int       miscompares = 0;
    int       cyc = 0;
    int       last_right_lsb_cyc = -100;
    logic     ready_level = 1'b0;
    logic     pulse_arm = 1'b0;

    pair_ev_t pair_q[$];
    int       ferr_q[$];
    int       valid_rises[$];
    logic [DW-1:0] cap_left = '0;
    logic [DW-1:0] cap_right = '0;

    // stream model state (slot level)
    logic          m_last_lr;
    logic          m_locked;
    logic          m_have_left;
    logic          m_short_pending;
    logic          m_cur_ok;
    logic [DW-1:0] m_left;

    // expected output state
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_left = '0;
    logic [DW-1:0] exp_right = '0;
    logic          exp_ovr = 1'b0;
    logic          exp_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic void model_reset();
        pair_q.delete();
        ferr_q.delete();
        m_last_lr       = 1'b0;
        m_locked        = 1'b0;
        m_have_left     = 1'b0;
        m_short_pending = 1'b0;
        m_cur_ok        = 1'b0;
        m_left          = '0;
    endfunction

    // Called at the first BCLK rise of a slot.
    function automatic void model_slot_start(input logic lr, input logic full, input int c);
        if (lr != m_last_lr) begin
            if (m_short_pending) begin
                ferr_q.push_back(c + SYNC_STAGES + 1);
                m_have_left     = 1'b0;
                m_locked        = (lr == 1'b0);
                m_short_pending = 1'b0;
            end else if (!m_locked && lr == 1'b0 && m_last_lr == 1'b1) begin
                m_locked = 1'b1;
            end
        end
        m_last_lr = lr;
        m_cur_ok  = m_locked && full;
        if (m_locked && !full) m_short_pending = 1'b1;
    endfunction

    // Called at the BCLK rise carrying the last captured bit of a word.
    function automatic void model_word_done(input logic lr, input logic [DW-1:0] top, input int c);
        pair_ev_t pe;
        if (!m_cur_ok) return;
        if (lr == 1'b0) begin
            m_left      = top;
            m_have_left = 1'b1;
        end else if (m_have_left) begin
            pe.cyc = c + SYNC_STAGES + 2;
            pe.l   = m_left;
            pe.r   = top;
            pair_q.push_back(pe);
            m_have_left = 1'b0;
        end
    endfunction

    // Slot of nbits BCLK periods: rise 0 sees the LR change, rise 1 is the delay bit,
    // then the word MSB first; anything not carrying word bits is driven as 1.
    task automatic send_slot(input logic lr, input logic [31:0] word, input int wbits, input int nbits);
        logic [DW-1:0] top;
        logic          d;
        top = DW'(word >> (wbits - DW));
        for (int j = 0; j < nbits; j++) begin
            d = (j >= 2 && (j - 2) < wbits) ? word[wbits - 1 - (j - 2)] : 1'b1;
            @(negedge clk);
            aud_bclk    = 1'b0;
            aud_adclrck = lr;
            aud_adcdat  = d;
            repeat (HALF - 1) @(negedge clk);
            aud_bclk = 1'b1;
            if (j == 0) model_slot_start(lr, nbits >= DW + 2, cyc);
            if (j == DW + 1) begin
                model_word_done(lr, top, cyc);
                if (lr) last_right_lsb_cyc = cyc;
            end
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int wbits);
        send_slot(1'b0, l, wbits, 32);
        send_slot(1'b1, r, wbits, 32);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            sample_ready = ready_level ||
                           (pulse_arm && cyc == last_right_lsb_cyc + SYNC_STAGES + 1);
        end
    end

    // Per-cycle compare against the handshake/flag model.
    initial begin
        logic     rdy_s, clr_s, ovr_evt, ferr_evt, prev_valid;
        pair_ev_t pe;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            rdy_s = sample_ready;
            clr_s = clr_flags;
            #1;
            if (!reset) begin
                exp_valid = 1'b0;
                exp_left  = '0;
                exp_right = '0;
                exp_ovr   = 1'b0;
                exp_ferr  = 1'b0;
            end else begin
                ovr_evt  = 1'b0;
                ferr_evt = 1'b0;
                if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
                    ferr_evt = 1'b1;
                    void'(ferr_q.pop_front());
                end
                if (pair_q.size() > 0 && pair_q[0].cyc == cyc) begin
                    pe = pair_q.pop_front();
                    if (!exp_valid || rdy_s) begin
                        exp_left  = pe.l;
                        exp_right = pe.r;
                        exp_valid = 1'b1;
                    end else begin
                        ovr_evt = 1'b1;
                    end
                end else if (exp_valid && rdy_s) begin
                    exp_valid = 1'b0;
                end
                exp_ovr  = ovr_evt  | (exp_ovr  & ~clr_s);
                exp_ferr = ferr_evt | (exp_ferr & ~clr_s);
            end
            check("valid", 32'(sample_valid), 32'(exp_valid));
            check("left", 32'(sample_left), 32'(exp_left));
            check("right", 32'(sample_right), 32'(exp_right));
            check("overrun", 32'(overrun), 32'(exp_ovr));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            if (sample_valid && !prev_valid) begin
                valid_rises.push_back(cyc);
                cap_left  = sample_left;
                cap_right = sample_right;
            end
            prev_valid = sample_valid;
        end
    end

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lsb2;
        int first;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b0;
        aud_adcdat  = 1'b0;
        clr_flags   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(sample_valid), 32'h0);
        check("rst_left", 32'(sample_left), 32'h0);
        check("rst_right", 32'(sample_right), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b1;

        // basic capture, first pair after LR alignment
        ready_level = 1'b1;
        base = valid_rises.size();
        send_frame(32'hA5C3, 32'h3C5A, 16);
        send_frame(32'hA5C3, 32'h3C5A, 16);
        lsb2 = last_right_lsb_cyc;
        send_frame(32'hA5C3, 32'h3C5A, 16);
        first = (valid_rises.size() > base) ? valid_rises[base] : -1;
        check("t1_pairs", 32'(valid_rises.size() - base), 32'd2);
        check("t1_latency", 32'(first - lsb2), 32'd4);
        check("t1_left", 32'(cap_left), 32'hA5C3);
        check("t1_right", 32'(cap_right), 32'h3C5A);

        // consumer stalled across two frames
        ready_level = 1'b0;
        send_frame(32'h1111, 32'h2222, 16);
        send_frame(32'h3333, 32'h4444, 16);
        check("t2_valid", 32'(sample_valid), 32'h1);
        check("t2_left", 32'(sample_left), 32'h1111);
        check("t2_right", 32'(sample_right), 32'h2222);
        check("t2_overrun", 32'(overrun), 32'h1);
        pulse_clr();
        check("t2_overrun_clr", 32'(overrun), 32'h0);

        // ready in the same cycle as a new load
        pulse_arm = 1'b1;
        send_frame(32'h5555, 32'h6666, 16);
        pulse_arm = 1'b0;
        check("t3_valid", 32'(sample_valid), 32'h1);
        check("t3_left", 32'(sample_left), 32'h5555);
        check("t3_right", 32'(sample_right), 32'h6666);
        check("t3_overrun", 32'(overrun), 32'h0);
        ready_level = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_drained", 32'(sample_valid), 32'h0);

        // short right word
        base = valid_rises.size();
        send_slot(1'b0, 32'h1234, 16, 32);
        send_slot(1'b1, 32'hBEEF, 16, 12);
        send_frame(32'h5678, 32'h9ABC, 16);
        check("t4_frame_err", 32'(frame_err), 32'h1);
        check("t4_pairs", 32'(valid_rises.size() - base), 32'd1);
        check("t4_left", 32'(cap_left), 32'h5678);
        check("t4_right", 32'(cap_right), 32'h9ABC);
        pulse_clr();
        check("t4_frame_err_clr", 32'(frame_err), 32'h0);

        // reset mid-SHIFT of a left word
        send_slot(1'b0, 32'hDEAD, 16, 10);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_valid", 32'(sample_valid), 32'h0);
        check("t5_left", 32'(sample_left), 32'h0);
        check("t5_right", 32'(sample_right), 32'h0);
        check("t5_overrun", 32'(overrun), 32'h0);
        check("t5_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = valid_rises.size();
        send_slot(1'b0, 32'hDEAD, 16, 22);
        send_slot(1'b1, 32'hBEEF, 16, 32);
        send_frame(32'h0F0F, 32'hF0F0, 16);
        check("t5_pairs", 32'(valid_rises.size() - base), 32'd1);
        check("t5_left_post", 32'(cap_left), 32'h0F0F);
        check("t5_right_post", 32'(cap_right), 32'hF0F0);

        // full-scale 24-bit codec words
        base = valid_rises.size();
        send_frame(32'h8000A5, 32'h7FFF5A, 24);
        check("t6_pairs", 32'(valid_rises.size() - base), 32'd1);
        check("t6_left", 32'(cap_left), 32'h8000);
        check("t6_right", 32'(cap_right), 32'h7FFF);

        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
